ctx_seq: RTL and testbench
==========================

CTX_SEQ -- requirements
Module: ctx_seq

Interface
REQ-001 Parameter SP_RESET, default 32'h0000_FF00, stack pointer value after reset.
REQ-002 Parameter STACK_LIMIT, default 32'h0000_F000, lowest legal stack address; used only under CTX_STACK_CHECK_EN.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 state_mode  in  2  registered mode from the control decoder: 0 IMEM, 1 CALL, 2 RET, 3 reserved.
REQ-006 sc  out  8  sequence count returned to the control decoder, range 0..16.
REQ-007 stall  out  1  freezes PC and blocks core-issued reg/dmem writes while high.
REQ-008 rf_addr  out  4  register-file port address owned by the sequencer.
REQ-009 rf_rdata  in  32  combinational register-file read data for rf_addr.
REQ-010 rf_wdata  out  32, rf_we  out  1  register-file write data and enable.
REQ-011 dmem_addr  out  32, dmem_wdata  out  32, dmem_we  out  1  data-memory request.
REQ-012 dmem_rdata  in  32  combinational data-memory read data for dmem_addr.
REQ-013 sp  out  32  current stack pointer.
REQ-014 err  out  1  sticky stack-bound violation flag.

Function
REQ-015 FSM states IDLE, SAVE, RESTORE and DONE; registered state, sc and sp.
REQ-016 IDLE: sc=0 and stall=0. state_mode=1 moves to SAVE, state_mode=2 moves to RESTORE, and 0 or 3 keeps IDLE.
REQ-017 SAVE, each cycle with sc=k (0..15): rf_addr=k, dmem_addr=sp-64+4k, dmem_wdata=rf_rdata, dmem_we=1, sc<=k+1.
REQ-018 RESTORE, each cycle with sc=k (0..15): dmem_addr=sp+4k, rf_addr=k, rf_wdata=dmem_rdata, rf_we=1, sc<=k+1.
REQ-019 When sc reaches 16, go to DONE; DONE lasts exactly 1 cycle with sc=16, no writes, then goes to IDLE with sc<=0.
REQ-020 On the DONE edge, sp<=sp-64 after a SAVE and sp<=sp+64 after a RESTORE.
REQ-021 stall=1 in SAVE, RESTORE and DONE.
REQ-022 Timing: a request sampled in IDLE at edge T gives the first access in cycle T+1, 16 access cycles, DONE in cycle T+17, and IDLE at T+18.
REQ-023 In the back-to-back case, state_mode=1 or 2 present in the first IDLE cycle after DONE starts a new sequence.
REQ-024 state_mode is ignored outside IDLE, so a mode change mid-sequence has no effect.
REQ-025 Address arithmetic is modulo 2^32; sp and dmem_addr wrap without a flag unless CTX_STACK_CHECK_EN is defined.
REQ-026 Outside SAVE and RESTORE, rf_we=0, dmem_we=0, and rf_addr, dmem_addr, dmem_wdata and rf_wdata are 0.

Reset
REQ-027 Reset value of every output: state IDLE, sc=0, sp=SP_RESET, err=0, stall=0, and all write enables, addresses and data 0.
REQ-028 Asserting rst_n low mid-sequence aborts the sequence immediately: no further writes, no sp update, and IDLE after release.

Configuration
REQ-029 Macro CTX_STACK_CHECK_EN; when defined, the stack-bound check below is active.
REQ-030 Check for SAVE: in IDLE, a SAVE with sp-64 < STACK_LIMIT goes to DONE with sc=16, with no writes, unchanged sp, and err<=1.
REQ-031 Check for RESTORE: in IDLE, a RESTORE with sp+64 > SP_RESET behaves the same way as REQ-030.
REQ-032 An aborted sequence still presents sc=16 for exactly one cycle, so the control decoder returns to IMEM.
REQ-033 err clears only on reset.
REQ-034 Without CTX_STACK_CHECK_EN: err is tied to 0, no bound checks are made, and REQ-025 wrap applies.

Verification
REQ-035 Reset then CALL: with rf[k]=32'hA000_0000+k, apply state_mode=1 -> 16 stores, mem[0xFEC0+4k]=rf[k], sc 0..16, stall high for 17 cycles, sp=0xFEC0.
REQ-036 CALL, clobber registers, then RET: state_mode=2 -> rf[k] restored to 32'hA000_0000+k, sp=0xFF00, exactly 16 rf_we pulses.
REQ-037 Mid-sequence mode change: state_mode forced to 2 at sc=5 of a SAVE -> SAVE completes unchanged, and the totals are 16 stores and 0 reg writes.
REQ-038 Reset mid-operation: rst_n low at sc=9 of a SAVE -> all outputs reset in the same cycle, sp=0xFF00, and no write after release.
REQ-039 With CTX_STACK_CHECK_EN, SP_RESET=32'h0000_F020 and a CALL -> no dmem_we, sc=16 for 1 cycle, err=1, sp unchanged. Without the macro -> the sequence runs and err=0.
REQ-040 Back-to-back and reserved modes: state_mode=3 in IDLE -> no activity. CALL immediately followed by CALL -> sp=0xFE80, with the second SAVE's first access in the cycle after the first IDLE.

Source files
------------

// File: rtl/ctx_seq_if.sv
// ctx_seq_if: bus between the context sequencer and the core.
//   state_mode  decoder mode request (0 IMEM, 1 CALL, 2 RET, 3 reserved)
//   sc          sequence count back to the decoder (0..16)
//   stall       freezes PC and core-issued writes while high
//   rf_*        register-file port owned by the sequencer (rf_rdata is combinational)
//   dmem_*      data-memory request port (dmem_rdata is combinational)
//   sp, err     current stack pointer and sticky stack-bound violation
// master modport: the sequencer. slave modport: the core / memories.
interface ctx_seq_if;
    logic [1:0]  state_mode;
    logic [7:0]  sc;
    logic        stall;
    logic [3:0]  rf_addr;
    logic [31:0] rf_rdata;
    logic [31:0] rf_wdata;
    logic        rf_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_we;
    logic [31:0] sp;
    logic        err;

    modport master (
        input  state_mode, rf_rdata, dmem_rdata,
        output sc, stall, rf_addr, rf_wdata, rf_we, dmem_addr, dmem_wdata, dmem_we, sp, err
    );

    modport slave (
        output state_mode, rf_rdata, dmem_rdata,
        input  sc, stall, rf_addr, rf_wdata, rf_we, dmem_addr, dmem_wdata, dmem_we, sp, err
    );
endinterface

// File: rtl/ctx_seq.sv
// ctx_seq: saves r0..r15 below the stack pointer on CALL and restores them on RET.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    ctx_seq_if.master: state_mode in, sc/stall/sp/err out, register-file
//          and data-memory ports driven by the sequencer
// Optional macro CTX_STACK_CHECK_EN: a CALL whose frame would fall below
// STACK_LIMIT, or a RET whose frame would rise above SP_RESET, is aborted
// (one DONE cycle, no writes, sp kept) and sets the sticky err flag.
// Without it err is tied low and sp wraps modulo 2^32.
module ctx_seq #(
    parameter logic [31:0] SP_RESET    = 32'h0000_FF00,
    parameter logic [31:0] STACK_LIMIT = 32'h0000_F000
) (
    input  logic       clk,
    input  logic       rst_n,
    ctx_seq_if.master  bus
);
`ifdef CTX_STACK_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;
    typedef enum logic [1:0] {SP_KEEP, SP_DEC, SP_INC} sp_op_t;

    state_t      state, state_nx;
    sp_op_t      op, op_nx;
    logic [7:0]  sc, sc_nx;
    logic [31:0] sp, sp_nx;
    logic        err, err_nx;
    logic        save_bad, rest_bad;
    logic        saving, restoring;
    logic [31:0] offs;

    // 33-bit compares so a frame crossing 0 or 2^32 still counts as out of bounds
    assign save_bad = CHECK && ({1'b0, sp} < {1'b0, STACK_LIMIT} + 33'd64);
    assign rest_bad = CHECK && ({1'b0, sp} + 33'd64 > {1'b0, SP_RESET});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sc    <= 8'd0;
            sp    <= SP_RESET;
            err   <= 1'b0;
            op    <= SP_KEEP;
        end else begin
            state <= state_nx;
            sc    <= sc_nx;
            sp    <= sp_nx;
            err   <= err_nx;
            op    <= op_nx;
        end
    end

    // op remembers which sp adjustment the DONE cycle owes; an aborted
    // request goes straight to DONE with SP_KEEP so it still shows sc=16
    always_comb begin
        state_nx = state;
        sc_nx    = sc;
        sp_nx    = sp;
        err_nx   = err;
        op_nx    = op;
        case (state)
            IDLE: begin
                if (bus.state_mode == 2'd1) begin
                    state_nx = save_bad ? DONE : SAVE;
                    sc_nx    = save_bad ? 8'd16 : 8'd0;
                    op_nx    = save_bad ? SP_KEEP : SP_DEC;
                    err_nx   = err | save_bad;
                end else if (bus.state_mode == 2'd2) begin
                    state_nx = rest_bad ? DONE : RESTORE;
                    sc_nx    = rest_bad ? 8'd16 : 8'd0;
                    op_nx    = rest_bad ? SP_KEEP : SP_INC;
                    err_nx   = err | rest_bad;
                end
            end
            SAVE, RESTORE: begin
                sc_nx    = sc + 8'd1;
                state_nx = (sc == 8'd15) ? DONE : state;
            end
            DONE: begin
                state_nx = IDLE;
                sc_nx    = 8'd0;
                sp_nx    = (op == SP_DEC) ? sp - 32'd64 : (op == SP_INC) ? sp + 32'd64 : sp;
                op_nx    = SP_KEEP;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign saving    = (state == SAVE);
    assign restoring = (state == RESTORE);
    assign offs      = 32'({sc, 2'b00});

    // SAVE fills the frame sp-64..sp-4 that sp will point to after DONE;
    // RESTORE reads the frame sp..sp+60 that sp leaves behind
    assign bus.rf_addr    = (saving || restoring) ? sc[3:0] : 4'd0;
    assign bus.dmem_addr  = saving ? sp - 32'd64 + offs : restoring ? sp + offs : 32'd0;
    assign bus.dmem_wdata = saving ? bus.rf_rdata : 32'd0;
    assign bus.dmem_we    = saving;
    assign bus.rf_wdata   = restoring ? bus.dmem_rdata : 32'd0;
    assign bus.rf_we      = restoring;
    assign bus.sc         = sc;
    assign bus.stall      = (state != IDLE);
    assign bus.sp         = sp;
    assign bus.err        = CHECK && err;
endmodule

// File: tb/tb_ctx_seq.sv
// tb_ctx_seq: randomized scoreboard bench for ctx_seq against a frame-level model.
module tb_ctx_seq;
    localparam logic [31:0] SP0 = 32'h0000_FF00;
    localparam logic [31:0] LIM = 32'h0000_F000;

    typedef struct {
        bit          is_mem;
        logic [3:0]  idx;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ctx_seq_if bus ();
    ctx_seq #(.SP_RESET(SP0), .STACK_LIMIT(LIM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    exp_t        sbq[$];
    int          n_chk = 0, n_fail = 0, n_dmem = 0, n_rf = 0;
    logic [31:0] env_rf [16];
    logic [31:0] env_mem [16384];
    bit          env_val [16384];
    logic        ld_en = 1'b0;
    logic [31:0] ld_val [16];
    logic [31:0] model_rf [16];
    logic [31:0] model_sp = SP0;
    bit          model_err = 1'b0;
    logic [31:0] model_mem [logic [31:0]];

    // contents of never-written memory words, known to both environment and model
    function automatic logic [31:0] fresh(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    assign bus.rf_rdata   = env_rf[bus.rf_addr];
    assign bus.dmem_rdata = env_val[bus.dmem_addr[15:2]] ? env_mem[bus.dmem_addr[15:2]] : fresh(bus.dmem_addr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16384; i++) env_val[i] <= 1'b0;
        end else begin
            if (ld_en) env_rf <= ld_val;
            else if (bus.rf_we) env_rf[bus.rf_addr] <= bus.rf_wdata;
            if (bus.dmem_we) begin
                env_mem[bus.dmem_addr[15:2]] <= bus.dmem_wdata;
                env_val[bus.dmem_addr[15:2]] <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (bus.dmem_we || bus.rf_we)) begin
            if (bus.dmem_we) n_dmem++;
            if (bus.rf_we) n_rf++;
            if (sbq.size() == 0) begin
                chk("unexpected_write", {30'd0, bus.dmem_we, bus.rf_we}, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("write_en", {30'd0, bus.dmem_we, bus.rf_we}, e.is_mem ? 32'd2 : 32'd1);
                chk("access_sc", 32'(bus.sc), 32'(e.idx));
                chk("rf_addr", 32'(bus.rf_addr), 32'(e.idx));
                chk("dmem_addr", bus.dmem_addr, e.addr);
                if (e.is_mem) chk("dmem_wdata", bus.dmem_wdata, e.data);
                else chk("rf_wdata", bus.rf_wdata, e.data);
            end
        end
    end

    task automatic model_push(input logic [1:0] mode, output bit abort);
        logic [31:0] a, d;
        abort = 1'b0;
`ifdef CTX_STACK_CHECK_EN
        abort = (mode == 2'd1) ? (model_sp < 32'd64 || model_sp - 32'd64 < LIM)
                               : (64'(model_sp) + 64'd64 > 64'(SP0));
`endif
        if (abort) begin
            model_err = 1'b1;
            return;
        end
        for (int k = 0; k < 16; k++) begin
            if (mode == 2'd1) begin
                a = model_sp - 32'd64 + 32'(4 * k);
                d = model_rf[k];
                model_mem[a] = d;
            end else begin
                a = model_sp + 32'(4 * k);
                d = model_mem.exists(a) ? model_mem[a] : fresh(a);
                model_rf[k] = d;
            end
            sbq.push_back('{mode == 2'd1, 4'(k), a, d});
        end
        model_sp = (mode == 2'd1) ? model_sp - 32'd64 : model_sp + 32'd64;
    endtask

    task automatic do_op(input logic [1:0] mode, input int gap, input bit force5);
        int cyc;
        int want;
        bit abort;
        logic [7:0] last_sc;
        cyc = 0;
        abort = 1'b0;
        last_sc = 8'd0;
        if (gap > 0) begin
            bus.state_mode = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0;
            repeat (gap) @(negedge clk);
        end
        chk("idle_stall", 32'(bus.stall), 32'd0);
        chk("idle_sc", 32'(bus.sc), 32'd0);
        bus.state_mode = mode;
        if (mode == 2'd1 || mode == 2'd2) model_push(mode, abort);
        want = (mode == 2'd1 || mode == 2'd2) ? (abort ? 1 : 17) : 0;
        @(negedge clk);
        while (bus.stall && cyc < 40) begin
            cyc++;
            last_sc = bus.sc;
            bus.state_mode = (force5 && bus.sc == 8'd5) ? 2'd2 : 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        chk("stall_cycles", 32'(cyc), 32'(want));
        if (want > 0) chk("done_sc", 32'(last_sc), 32'd16);
        chk("sp", bus.sp, model_sp);
        chk("err", 32'(bus.err), 32'(model_err));
        chk("sbq_drained", 32'(sbq.size()), 32'd0);
    endtask

    task automatic load(input bit rnd);
        bus.state_mode = 2'd0;
        for (int k = 0; k < 16; k++) begin
            ld_val[k] = rnd ? $urandom : 32'hA000_0000 + 32'(k);
            model_rf[k] = ld_val[k];
        end
        ld_en = 1'b1;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_stall"}, 32'(bus.stall), 32'd0);
        chk({tag, "_sc"}, 32'(bus.sc), 32'd0);
        chk({tag, "_sp"}, bus.sp, SP0);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
        chk({tag, "_we"}, {30'd0, bus.dmem_we, bus.rf_we}, 32'd0);
        chk({tag, "_dmem_addr"}, bus.dmem_addr, 32'd0);
        chk({tag, "_rf_addr"}, 32'(bus.rf_addr), 32'd0);
        chk({tag, "_wdata"}, bus.dmem_wdata | bus.rf_wdata, 32'd0);
    endtask

    task automatic reset_mid_save(input logic [7:0] at_sc);
        bit abort;
        int guard;
        guard = 0;
        bus.state_mode = 2'd1;
        model_push(2'd1, abort);
        @(negedge clk);
        bus.state_mode = 2'd0;
        while (bus.sc != at_sc && guard < 40) begin
            guard++;
            @(negedge clk);
        end
        chk("reached_sc", 32'(bus.sc), 32'(at_sc));
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        sbq.delete();
        model_mem.delete();
        model_sp = SP0;
        model_err = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_reset_stall", 32'(bus.stall), 32'd0);
        chk("post_reset_sp", bus.sp, SP0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r, g, d0, r0;
        logic [31:0] a;
        bus.state_mode = 2'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        load(1'b0);

        // CALL with rf[k] = A000_0000+k
        do_op(2'd1, 0, 1'b0);
        chk("sp_after_call", bus.sp, 32'h0000_FEC0);
        for (int k = 0; k < 16; k++) begin
            a = 32'h0000_FEC0 + 32'(4 * k);
            chk("stack_mem", env_mem[a[15:2]], 32'hA000_0000 + 32'(k));
        end

        // clobber registers then RET restores them
        load(1'b1);
        r0 = n_rf;
        do_op(2'd2, 1, 1'b0);
        chk("ret_rf_we_pulses", 32'(n_rf - r0), 32'd16);
        chk("sp_after_ret", bus.sp, SP0);
        for (int k = 0; k < 16; k++) chk("restored_rf", env_rf[k], 32'hA000_0000 + 32'(k));

        // mode forced to RET at sc=5 of a SAVE
        d0 = n_dmem;
        r0 = n_rf;
        do_op(2'd1, 2, 1'b1);
        chk("midchange_stores", 32'(n_dmem - d0), 32'd16);
        chk("midchange_rf_we", 32'(n_rf - r0), 32'd0);
        do_op(2'd2, 0, 1'b0);

        // reserved mode, then back-to-back CALLs and RETs
        do_op(2'd3, 2, 1'b0);
        do_op(2'd0, 1, 1'b0);
        do_op(2'd1, 1, 1'b0);
        do_op(2'd1, 0, 1'b0);
        chk("sp_back_to_back", bus.sp, 32'h0000_FE80);
        do_op(2'd2, 0, 1'b0);
        do_op(2'd2, 0, 1'b0);

        // reset at sc=9 of a SAVE
        reset_mid_save(8'd9);

        // walk the stack down past STACK_LIMIT and back up past SP_RESET
        load(1'b1);
        for (int i = 0; i < 61; i++) do_op(2'd1, 0, 1'b0);
        for (int i = 0; i < 61; i++) do_op(2'd2, 0, 1'b0);
        do_op(2'd2, 1, 1'b0);
        do_op(2'd1, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            g = $urandom_range(0, 2);
            if (r < 4 && model_sp >= LIM + 32'd128) do_op(2'd1, g, 1'b0);
            else if (r < 8 && model_sp <= SP0 - 32'd64) do_op(2'd2, g, 1'b0);
            else if (r == 9) load(1'b1);
            else do_op(($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0, g, 1'b0);
        end

        bus.state_mode = 2'd0;
        repeat (5) @(negedge clk);
        chk("final_sbq_empty", 32'(sbq.size()), 32'd0);
        chk("final_stall", 32'(bus.stall), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
